// File: rtl/dmem_pkg.sv
`timescale 1ns/1ps
// Shared types and defaults for the data-memory responder: FSM states,
// default geometry and the address legality check.
package dmem_pkg;

    localparam int DMEM_DEPTH       = 256;
    localparam int DMEM_WAIT_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Misaligned or beyond the last word; compared in 64 bits so DEPTH*4 never wraps.
    function automatic logic addr_err(input logic [31:0] addr, input int depth);
        return (addr[1:0] != 2'b00) || ({32'd0, addr} >= (64'(depth) << 2));
    endfunction

endpackage

// File: rtl/dmem_array.sv
`timescale 1ns/1ps
// DEPTH x 32 word storage: synchronous write, combinational read.
// Contents are deliberately not reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
// Single-outstanding data-memory responder: accepts one load/store, inserts
// WAIT_CYCLES wait states, then presents a one-cycle response pulse.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = DMEM_DEPTH,
    parameter int WAIT_CYCLES = DMEM_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    dmem_state_t   state_reg;
    logic [CW-1:0] cnt_reg;
    logic          write_reg;
    logic          err_reg;
    logic [AW-1:0] idx_reg;
    logic [31:0]   wdata_reg;
    logic          resp_valid_reg;
    logic          resp_err_reg;
    logic [31:0]   resp_rdata_reg;

    logic          cur_write;
    logic          cur_err;
    logic [AW-1:0] cur_idx;
    logic [31:0]   rd_data;
    logic [31:0]   load_data;
    logic          mem_we;

    // In IDLE the transaction is still on the request bus; afterwards it lives
    // in the latched copies. This lets WAIT_CYCLES=0 go straight to RESP.
    assign cur_write = (state_reg == IDLE) ? req_write : write_reg;
    assign cur_err   = (state_reg == IDLE) ? addr_err(req_addr, DEPTH) : err_reg;
    assign cur_idx   = (state_reg == IDLE) ? req_addr[AW+1:2] : idx_reg;
    assign load_data = (!cur_write && !cur_err) ? rd_data : 32'd0;

    // Store commits on the edge that closes RESP, unless reset abandons it.
    assign mem_we = (state_reg == RESP) && write_reg && !err_reg && !rst;

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (idx_reg),
        .wdata (wdata_reg),
        .raddr (cur_idx),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= '0;
        end else begin
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        write_reg <= req_write;
                        err_reg   <= cur_err;
                        idx_reg   <= req_addr[AW+1:2];
                        wdata_reg <= req_wdata;
                        if (WAIT_CYCLES == 0) begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                            resp_err_reg   <= cur_err;
                            resp_rdata_reg <= load_data;
                        end else begin
                            state_reg <= WAIT;
                            cnt_reg   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_reg == '0) begin
                        state_reg      <= RESP;
                        resp_valid_reg <= 1'b1;
                        resp_err_reg   <= cur_err;
                        resp_rdata_reg <= load_data;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_reg == IDLE);

    // Reset asserted during RESP suppresses the pulse that cycle.
    assign resp_valid = resp_valid_reg & ~rst;
    assign resp_err   = resp_err_reg & ~rst;
    assign resp_rdata = rst ? 32'd0 : resp_rdata_reg;

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
// Scoreboard bench for dmem_responder: instance 0 uses WAIT_CYCLES=2,
// instance 1 uses WAIT_CYCLES=0; a negedge monitor checks every response.
module tb_dmem_responder;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req_valid = '0;
    logic [1:0]       req_ready;
    logic [1:0]       req_write = '0;
    logic [1:0][31:0] req_addr  = '0;
    logic [1:0][31:0] req_wdata = '0;
    logic [1:0]       resp_valid;
    logic [1:0][31:0] resp_rdata;
    logic [1:0]       resp_err;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid[0]),
        .req_ready  (req_ready[0]),
        .req_write  (req_write[0]),
        .req_addr   (req_addr[0]),
        .req_wdata  (req_wdata[0]),
        .resp_valid (resp_valid[0]),
        .resp_rdata (resp_rdata[0]),
        .resp_err   (resp_err[0])
    );

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid[1]),
        .req_ready  (req_ready[1]),
        .req_write  (req_write[1]),
        .req_addr   (req_addr[1]),
        .req_wdata  (req_wdata[1]),
        .resp_valid (resp_valid[1]),
        .resp_rdata (resp_rdata[1]),
        .resp_err   (resp_err[1])
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          accept;
        string       name;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per response pulse and checks data and latency.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (resp_valid[d]) begin
                if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                    check($sformatf("dut%0d_unexpected_resp", d), {31'd0, resp_valid[d]}, 32'd0);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    check({e.name, "_err"}, {31'd0, resp_err[d]}, {31'd0, e.err});
                    check({e.name, "_rdata"}, resp_rdata[d], e.rdata);
                    check({e.name, "_latency"}, 32'(cyc - e.accept + 1), (d == 0) ? 32'd3 : 32'd1);
                    $display("resp dut%0d %-14s err=%0b rdata=%h latency=%0d",
                             d, e.name, resp_err[d], resp_rdata[d], cyc - e.accept + 1);
                end
            end else if (!rst) begin
                check($sformatf("dut%0d_idle_zero", d), {resp_err[d], resp_rdata[d][30:0]}, 32'd0);
            end
        end
    end

    // Called at a negedge; returns at the negedge following acceptance.
    task automatic issue(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit exp_err, input logic [31:0] exp_rdata, input string name,
                         input bit hold, input bit push, output int acc);
        exp_t e;
        int   n = 0;
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        acc = -1;
        if (n >= 20) begin
            check({name, "_ready_timeout"}, {31'd0, req_ready[d]}, 32'd1);
            req_valid[d] = 1'b0;
        end else begin
            e.err = exp_err;
            e.rdata = exp_rdata;
            e.accept = cyc + 1;
            e.name = name;
            if (push) begin
                if (d == 0) q0.push_back(e);
                else q1.push_back(e);
            end
            @(posedge clk);
            acc = cyc;
            #1;
            // Scramble the bus after acceptance: the DUT must use its latched copy.
            req_addr[d]  = 32'hFFFF_FFFF;
            req_wdata[d] = 32'h0BAD_0BAD;
            req_write[d] = ~wr;
            if (!hold) req_valid[d] = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while (((d == 0 ? q0.size() : q1.size()) != 0 || !req_ready[d]) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) check($sformatf("dut%0d_idle_timeout", d), {31'd0, req_ready[d]}, 32'd1);
    endtask

    task automatic xact(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit exp_err, input logic [31:0] exp_rdata, input string name);
        int acc;
        issue(d, wr, addr, wdata, exp_err, exp_rdata, name, 1'b0, 1'b1, acc);
        wait_idle(d);
    endtask

    initial begin
        int a1, a2, a3;
        repeat (3) @(negedge clk);
        check("reset_ready_w2", {31'd0, req_ready[0]}, 32'd1);
        check("reset_ready_w0", {31'd0, req_ready[1]}, 32'd1);
        check("reset_resp_valid", {30'd0, resp_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors on the WAIT_CYCLES=2 instance.
        xact(0, 1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'd0,        "st_0x000");
        xact(0, 1'b1, 32'h0000_03FC, 32'h3FC3_FC3F, 1'b0, 32'd0,        "st_0x3fc");
        xact(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'd0,        "st_0x010");
        xact(0, 1'b0, 32'h0000_0010, 32'd0,         1'b0, 32'hDEAD_BEEF, "ld_0x010");
        xact(0, 1'b0, 32'h0000_0013, 32'd0,         1'b1, 32'd0,        "ld_0x013_mis");
        xact(0, 1'b1, 32'h0000_0013, 32'hBAD0_BAD0, 1'b1, 32'd0,        "st_0x013_mis");
        xact(0, 1'b0, 32'h0000_0010, 32'd0,         1'b0, 32'hDEAD_BEEF, "ld_0x010_again");
        xact(0, 1'b1, 32'h0000_0400, 32'h5555_AAAA, 1'b1, 32'd0,        "st_0x400_oor");
        xact(0, 1'b0, 32'hFFFF_FFFC, 32'd0,         1'b1, 32'd0,        "ld_top_oor");
        xact(0, 1'b0, 32'h0000_0000, 32'd0,         1'b0, 32'h1111_1111, "ld_0x000");
        xact(0, 1'b0, 32'h0000_03FC, 32'd0,         1'b0, 32'h3FC3_FC3F, "ld_0x3fc");
        xact(0, 1'b1, 32'h0000_0020, 32'hA5A5_0020, 1'b0, 32'd0,        "st_0x020");

        // Store abandoned by reset in its WAIT cycle: no response, no commit.
        issue(0, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0, 32'd0, "st_0x020_abort", 1'b0, 1'b0, a1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", {31'd0, req_ready[0]}, 32'd1);
        check("abort_resp_valid", {31'd0, resp_valid[0]}, 32'd0);
        repeat (4) @(negedge clk);
        xact(0, 1'b0, 32'h0000_0020, 32'd0, 1'b0, 32'hA5A5_0020, "ld_0x020_kept");

        // req_valid held high: back-to-back acceptances every 4 cycles.
        issue(0, 1'b0, 32'h0000_0010, 32'd0, 1'b0, 32'hDEAD_BEEF, "hold_ld_0x010", 1'b1, 1'b1, a1);
        issue(0, 1'b0, 32'h0000_0000, 32'd0, 1'b0, 32'h1111_1111, "hold_ld_0x000", 1'b1, 1'b1, a2);
        issue(0, 1'b0, 32'h0000_03FC, 32'd0, 1'b0, 32'h3FC3_FC3F, "hold_ld_0x3fc", 1'b0, 1'b1, a3);
        check("hold_spacing_1", 32'(a2 - a1), 32'd4);
        check("hold_spacing_2", 32'(a3 - a2), 32'd4);
        wait_idle(0);

        // WAIT_CYCLES=0 instance: one-cycle latency, acceptances 2 cycles apart.
        issue(1, 1'b1, 32'h0000_0008, 32'hCAFE_F00D, 1'b0, 32'd0,         "w0_st_0x008", 1'b1, 1'b1, a1);
        issue(1, 1'b0, 32'h0000_0008, 32'd0,         1'b0, 32'hCAFE_F00D, "w0_ld_0x008", 1'b1, 1'b1, a2);
        issue(1, 1'b0, 32'h0000_0009, 32'd0,         1'b1, 32'd0,         "w0_ld_0x009", 1'b0, 1'b1, a3);
        check("w0_spacing_1", 32'(a2 - a1), 32'd2);
        check("w0_spacing_2", 32'(a3 - a2), 32'd2);
        wait_idle(1);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 256, is the number of 32-bit words held.
REQ-002 Parameter WAIT_CYCLES, default 2, is the number of wait states between request acceptance and response.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 resp_valid  output  1  one-cycle response pulse.
REQ-011 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-012 resp_err  output  1  request rejected (misaligned or out of range); qualified by resp_valid.

Function
REQ-013 FSM states SHALL be IDLE, WAIT and RESP.
REQ-014 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle where req_valid && req_ready.
REQ-015 On acceptance, write, addr and wdata SHALL be latched; later input changes have no effect on that transaction.
REQ-016 IDLE->WAIT on acceptance with WAIT_CYCLES>0, loading a down-counter with WAIT_CYCLES-1; IDLE->RESP directly when WAIT_CYCLES=0.
REQ-017 WAIT->RESP when the counter reaches 0; otherwise decrement and stay.
REQ-018 RESP SHALL last exactly one cycle with resp_valid=1, then return to IDLE.
REQ-019 Latency: acceptance at edge N gives resp_valid high in cycle N+WAIT_CYCLES+1; the next acceptance is possible no earlier than the cycle after RESP.
REQ-020 Word index SHALL be addr[log2(DEPTH)+1:2].
REQ-021 Error when addr[1:0]!=0 or addr>=DEPTH*4; resp_err=1, resp_rdata=0, memory unchanged.
REQ-022 Store without error SHALL commit to the array on the RESP-cycle edge; resp_rdata=0.
REQ-023 Load without error SHALL drive resp_rdata with the array word during RESP; resp_err=0.
REQ-024 resp_rdata and resp_err SHALL be 0 whenever resp_valid=0.
REQ-025 A load to an address stored by the immediately preceding transaction SHALL return the new data.
REQ-026 req_valid dropping while not in IDLE SHALL have no effect.

Reset
REQ-027 rst SHALL force IDLE, counter=0, req_ready=1 in the following cycle, and resp_valid=0, resp_rdata=0, resp_err=0.
REQ-028 rst asserted in WAIT or RESP SHALL abandon the transaction: no store commit and no response.
REQ-029 Array contents SHALL NOT be cleared by rst.

Structure
REQ-030 The state enum and the default DEPTH/WAIT_CYCLES constants SHALL live in a shared package, dmem_pkg.
REQ-031 Storage SHALL be a single sub-module dmem_array (synchronous write, combinational read, DEPTH x 32).

Verification
REQ-032 Store 0xDEADBEEF at 0x10, then load 0x10 -> resp_valid 3 cycles after each acceptance; the load returns 0xDEADBEEF with resp_err=0.
REQ-033 Load at 0x13 -> resp_err=1, resp_rdata=0; a store at 0x13 leaves word 4 unchanged.
REQ-034 Store at 0x400 with DEPTH=256 -> resp_err=1, and no array word changes.
REQ-035 Hold req_valid high continuously -> req_ready low through WAIT and RESP; acceptances exactly 4 cycles apart.
REQ-036 Assert rst in the WAIT cycle of a store of 0x12345678 to 0x20 -> no resp_valid; a subsequent load of 0x20 returns the prior value.
REQ-037 WAIT_CYCLES=0: load accepted at edge N -> resp_valid in cycle N+1; acceptances 2 cycles apart.
